// File: rtl/pipe_hazard_pkg.sv
// Shared types for the pipeline hazard/forwarding controller: scoreboard slots,
// forward-select encoding and the per-cycle control mode.
package pipe_hazard_pkg;

  // Slot address fields are sized for the widest register file supported.
  localparam int unsigned REG_AW_MAX = 8;

  typedef logic [REG_AW_MAX-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_HZ,
    MODE_MC,
    MODE_FRZ
  } hz_mode_e;

  typedef struct packed {
    logic      v;
    reg_addr_t rd;
    logic      wen;
    logic      ld;
  } sb_slot_t;

  typedef struct packed {
    sb_slot_t  base;
    reg_addr_t rs1;
    reg_addr_t rs2;
    logic      rs1_used;
    logic      rs2_used;
  } sb_ex_slot_t;

  localparam sb_slot_t    SB_BUBBLE    = '0;
  localparam sb_ex_slot_t SB_EX_BUBBLE = '0;

  // x0 is hardwired zero, so a write to it never creates a dependency.
  function automatic logic sb_writes(input sb_slot_t s, input reg_addr_t r);
    return s.v && s.wen && (s.rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/pipe_hazard_if.sv
// ID-stage instruction fields in, stall/flush/forward controls out.
interface pipe_hazard_if #(
  parameter int unsigned REG_AW = 5
);
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic              id_rs1_used_i;
  logic              id_rs2_used_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_wen_i;
  logic              id_load_i;
  logic              id_branch_i;
  logic              id_mc_i;
  logic              redirect_i;
  logic              ext_stall_i;

  logic              stall_pc_o;
  logic              stall_ifid_o;
  logic              flush_ifid_o;
  logic              bubble_idex_o;
  logic              hold_idex_o;
  logic              bubble_exmem_o;
  logic [1:0]        fwd_a_o;
  logic [1:0]        fwd_b_o;
  logic              fwd_br_a_o;
  logic              fwd_br_b_o;
  logic              mc_busy_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_i, id_wen_i, id_load_i, id_branch_i, id_mc_i,
           redirect_i, ext_stall_i,
    input  stall_pc_o, stall_ifid_o, flush_ifid_o, bubble_idex_o,
           hold_idex_o, bubble_exmem_o, fwd_a_o, fwd_b_o,
           fwd_br_a_o, fwd_br_b_o, mc_busy_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_i, id_wen_i, id_load_i, id_branch_i, id_mc_i,
           redirect_i, ext_stall_i,
    output stall_pc_o, stall_ifid_o, flush_ifid_o, bubble_idex_o,
           hold_idex_o, bubble_exmem_o, fwd_a_o, fwd_b_o,
           fwd_br_a_o, fwd_br_b_o, mc_busy_o
  );
endinterface

// File: rtl/pipe_fwd_sel.sv
// Per-operand forward source select: MEM result beats WB result; loads in MEM
// are not forwardable from there.
module pipe_fwd_sel
  import pipe_hazard_pkg::*;
(
  input  logic      used_i,
  input  reg_addr_t src_i,
  input  sb_slot_t  mem_i,
  input  sb_slot_t  wb_i,
  output fwd_sel_e  sel_o
);

  // Load data is already valid in WB, so the WB load flag is irrelevant here.
  logic unused_wb_ld;
  assign unused_wb_ld = wb_i.ld;

  always_comb begin
    sel_o = FWD_RF;
    if (used_i && sb_writes(mem_i, src_i) && !mem_i.ld) begin
      sel_o = FWD_MEM;
    end else if (used_i && sb_writes(wb_i, src_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Central hazard/forwarding controller for the 5-stage pipeline.
// Optional HAZARD_PERF_EN adds saturating stall/multi-cycle/flush counters.
module pipe_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned EX_MC_CYCLES = 4,
  parameter int unsigned PERF_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_if.slave      hif
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_o,
  output logic [PERF_W-1:0] perf_mc_o,
  output logic [PERF_W-1:0] perf_flush_o
`endif
);

  localparam int unsigned     MC_W    = $clog2(EX_MC_CYCLES);
  localparam logic [MC_W-1:0] MC_LOAD = MC_W'(EX_MC_CYCLES - 1);

  sb_ex_slot_t     ex_q, ex_d, id_slot;
  sb_slot_t        mem_q, mem_d, wb_q, wb_d;
  logic [MC_W-1:0] mc_cnt_q, mc_cnt_d;

  logic [REG_AW-1:0] id_rs1_raw, id_rs2_raw, id_rd_raw;
  reg_addr_t         id_rs1, id_rs2, id_rd;
  logic              use1, use2, load_use, br_haz, hz, mc_busy;
  hz_mode_e          mode;

  logic stall_pc, stall_ifid, bubble_idex, hold_idex, bubble_exmem;
  fwd_sel_e fwd_a, fwd_b, fwd_br_a, fwd_br_b;

  assign id_rs1_raw = hif.id_rs1_i;
  assign id_rs2_raw = hif.id_rs2_i;
  assign id_rd_raw  = hif.id_rd_i;
  assign id_rs1     = REG_AW_MAX'(id_rs1_raw);
  assign id_rs2     = REG_AW_MAX'(id_rs2_raw);
  assign id_rd      = REG_AW_MAX'(id_rd_raw);

  assign use1    = hif.id_valid_i && hif.id_rs1_used_i;
  assign use2    = hif.id_valid_i && hif.id_rs2_used_i;
  assign mc_busy = (mc_cnt_q != '0);

  assign load_use = ex_q.base.ld &&
                    ((use1 && sb_writes(ex_q.base, id_rs1)) ||
                     (use2 && sb_writes(ex_q.base, id_rs2)));

  // ID-stage compare cannot take an EX result, nor a load still in MEM.
  assign br_haz = hif.id_branch_i &&
                  ((use1 && (sb_writes(ex_q.base, id_rs1) ||
                             (sb_writes(mem_q, id_rs1) && mem_q.ld))) ||
                   (use2 && (sb_writes(ex_q.base, id_rs2) ||
                             (sb_writes(mem_q, id_rs2) && mem_q.ld))));

  assign hz = load_use || br_haz;

  always_comb begin
    if (hif.ext_stall_i)  mode = MODE_FRZ;
    else if (mc_busy)     mode = MODE_MC;
    else if (hz)          mode = MODE_HZ;
    else                  mode = MODE_RUN;
  end

  always_comb begin
    stall_pc     = 1'b0;
    stall_ifid   = 1'b0;
    bubble_idex  = 1'b0;
    hold_idex    = 1'b0;
    bubble_exmem = 1'b0;
    unique case (mode)
      MODE_FRZ: begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        hold_idex  = 1'b1;
      end
      MODE_MC: begin
        stall_pc     = 1'b1;
        stall_ifid   = 1'b1;
        hold_idex    = 1'b1;
        bubble_exmem = 1'b1;
      end
      MODE_HZ: begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        bubble_idex = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    id_slot          = SB_EX_BUBBLE;
    id_slot.base.v   = hif.id_valid_i;
    id_slot.base.rd  = id_rd;
    id_slot.base.wen = hif.id_wen_i;
    id_slot.base.ld  = hif.id_load_i;
    id_slot.rs1      = id_rs1;
    id_slot.rs2      = id_rs2;
    id_slot.rs1_used = hif.id_rs1_used_i;
    id_slot.rs2_used = hif.id_rs2_used_i;
  end

  always_comb begin
    ex_d     = ex_q;
    mem_d    = mem_q;
    wb_d     = wb_q;
    mc_cnt_d = mc_cnt_q;
    unique case (mode)
      MODE_FRZ: ;
      MODE_MC: begin
        mem_d    = SB_BUBBLE;
        wb_d     = mem_q;
        mc_cnt_d = mc_cnt_q - MC_W'(1);
      end
      MODE_HZ: begin
        ex_d  = SB_EX_BUBBLE;
        mem_d = ex_q.base;
        wb_d  = mem_q;
      end
      default: begin
        ex_d  = id_slot;
        mem_d = ex_q.base;
        wb_d  = mem_q;
        if (hif.id_valid_i && hif.id_mc_i) mc_cnt_d = MC_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q     <= SB_EX_BUBBLE;
      mem_q    <= SB_BUBBLE;
      wb_q     <= SB_BUBBLE;
      mc_cnt_q <= '0;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  pipe_fwd_sel u_fwd_a (
    .used_i (ex_q.rs1_used), .src_i (ex_q.rs1),
    .mem_i  (mem_q),         .wb_i  (wb_q),
    .sel_o  (fwd_a)
  );

  pipe_fwd_sel u_fwd_b (
    .used_i (ex_q.rs2_used), .src_i (ex_q.rs2),
    .mem_i  (mem_q),         .wb_i  (wb_q),
    .sel_o  (fwd_b)
  );

  pipe_fwd_sel u_fwd_br_a (
    .used_i (hif.id_branch_i && use1), .src_i (id_rs1),
    .mem_i  (mem_q),                   .wb_i  (SB_BUBBLE),
    .sel_o  (fwd_br_a)
  );

  pipe_fwd_sel u_fwd_br_b (
    .used_i (hif.id_branch_i && use2), .src_i (id_rs2),
    .mem_i  (mem_q),                   .wb_i  (SB_BUBBLE),
    .sel_o  (fwd_br_b)
  );

  assign hif.stall_pc_o     = stall_pc;
  assign hif.stall_ifid_o   = stall_ifid;
  assign hif.flush_ifid_o   = hif.redirect_i && !stall_ifid;
  assign hif.bubble_idex_o  = bubble_idex;
  assign hif.hold_idex_o    = hold_idex;
  assign hif.bubble_exmem_o = bubble_exmem;
  assign hif.fwd_a_o        = fwd_a;
  assign hif.fwd_b_o        = fwd_b;
  assign hif.fwd_br_a_o     = (fwd_br_a == FWD_MEM);
  assign hif.fwd_br_b_o     = (fwd_br_b == FWD_MEM);
  assign hif.mc_busy_o      = mc_busy;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] perf_stall_q, perf_mc_q, perf_flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_mc_q    <= '0;
      perf_flush_q <= '0;
    end else if (!hif.ext_stall_i) begin
      if (mode == MODE_HZ && !(&perf_stall_q)) perf_stall_q <= perf_stall_q + PERF_W'(1);
      if (mode == MODE_MC && !(&perf_mc_q))    perf_mc_q    <= perf_mc_q + PERF_W'(1);
      if (hif.flush_ifid_o && !(&perf_flush_q)) perf_flush_q <= perf_flush_q + PERF_W'(1);
    end
  end

  assign perf_stall_o = perf_stall_q;
  assign perf_mc_o    = perf_mc_q;
  assign perf_flush_o = perf_flush_q;
`else
  logic [PERF_W-1:0] unused_perf;
  assign unused_perf = '0;
`endif

endmodule
